// File: rtl/aes_ctr.sv
// AES-CTR sequencer: drives one external aes_enc core, XORs data with keystream.
// Optional AES_CTR_WRAP_ERR_EN makes counter wrap sticky and blocks new data.
module aes_ctr #(
  parameter int CTR_WIDTH = 32
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [127:0] ctr_iv,
  input  logic         ctr_load,
  input  logic [127:0] s_data,
  input  logic         s_data_valid,
  output logic         s_data_ready,
  output logic [127:0] m_data,
  output logic         m_data_valid,
  input  logic         m_data_ready,
  output logic [127:0] aes_block,
  output logic         aes_valid,
  input  logic         aes_ready,
  input  logic [127:0] aes_keystream,
  output logic         busy,
  output logic         ctr_wrap
);

  typedef enum logic [1:0] {
    IDLE,
    ISSUE_WAIT_BUSY,
    WAIT_DONE,
    OUT
  } state_t;

  localparam logic [127:0] LOW_MASK =
    (CTR_WIDTH >= 128) ? {128{1'b1}} :
    ((128'd1 << CTR_WIDTH) - 128'd1);

  state_t       r_state, w_state;
  logic [127:0] r_ctr, w_ctr;
  logic [127:0] r_latch, w_latch;
  logic [127:0] r_m_data, w_m_data;
  logic         r_m_valid, w_m_valid;
  logic         r_s_ready, w_s_ready;
  logic [127:0] r_aes_block, w_aes_block;
  logic         r_aes_valid, w_aes_valid;
  logic [1:0]   r_tmo, w_tmo;
  logic [127:0] w_ctr_inc;
  logic         w_block;

  // Only the low CTR_WIDTH bits count; the nonce bits pass through.
  assign w_ctr_inc = (r_ctr & ~LOW_MASK) |
                     ((r_ctr + 128'd1) & LOW_MASK);

`ifdef AES_CTR_WRAP_ERR_EN
  logic r_wrap, w_wrap;
  logic w_ctr_wraps;
  assign w_ctr_wraps = (r_ctr & LOW_MASK) == LOW_MASK;
  assign w_block     = r_wrap;
  assign ctr_wrap    = r_wrap;
`else
  assign w_block  = 1'b0;
  assign ctr_wrap = 1'b0;
`endif

  always_comb begin
    w_state     = r_state;
    w_ctr       = r_ctr;
    w_latch     = r_latch;
    w_m_data    = r_m_data;
    w_m_valid   = r_m_valid;
    w_s_ready   = 1'b0;
    w_aes_block = r_aes_block;
    w_aes_valid = 1'b0;
    w_tmo       = r_tmo;
`ifdef AES_CTR_WRAP_ERR_EN
    w_wrap      = r_wrap;
`endif
    unique case (r_state)
      IDLE: begin
        w_tmo = 2'd0;
        if (ctr_load) begin
          w_ctr = ctr_iv;
`ifdef AES_CTR_WRAP_ERR_EN
          w_wrap = 1'b0;
`endif
        end else if (s_data_valid && aes_ready && !w_block) begin
          w_latch     = s_data;
          w_s_ready   = 1'b1;
          w_aes_valid = 1'b1;
          w_aes_block = r_ctr;
          w_state     = ISSUE_WAIT_BUSY;
        end
      end
      ISSUE_WAIT_BUSY: begin
        // Core still ready after 4 cycles means it missed the pulse.
        if (!aes_ready) begin
          w_tmo   = 2'd0;
          w_state = WAIT_DONE;
        end else if (r_tmo == 2'd3) begin
          w_tmo       = 2'd0;
          w_aes_valid = 1'b1;
        end else begin
          w_tmo = r_tmo + 2'd1;
        end
      end
      WAIT_DONE: begin
        if (aes_ready) begin
          w_m_data  = r_latch ^ aes_keystream;
          w_m_valid = 1'b1;
          w_ctr     = w_ctr_inc;
`ifdef AES_CTR_WRAP_ERR_EN
          w_wrap = r_wrap | w_ctr_wraps;
`endif
          w_state = OUT;
        end
      end
      OUT: begin
        if (m_data_ready) begin
          w_m_valid = 1'b0;
          w_state   = IDLE;
        end
      end
      default: w_state = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state     <= IDLE;
      r_ctr       <= '0;
      r_latch     <= '0;
      r_m_data    <= '0;
      r_m_valid   <= 1'b0;
      r_s_ready   <= 1'b0;
      r_aes_block <= '0;
      r_aes_valid <= 1'b0;
      r_tmo       <= 2'd0;
    end else begin
      r_state     <= w_state;
      r_ctr       <= w_ctr;
      r_latch     <= w_latch;
      r_m_data    <= w_m_data;
      r_m_valid   <= w_m_valid;
      r_s_ready   <= w_s_ready;
      r_aes_block <= w_aes_block;
      r_aes_valid <= w_aes_valid;
      r_tmo       <= w_tmo;
    end
  end

`ifdef AES_CTR_WRAP_ERR_EN
  always_ff @(posedge clk) begin
    if (!rst_n) r_wrap <= 1'b0;
    else        r_wrap <= w_wrap;
  end
`endif

  assign s_data_ready = r_s_ready;
  assign m_data       = r_m_data;
  assign m_data_valid = r_m_valid;
  assign aes_block    = r_aes_block;
  assign aes_valid    = r_aes_valid;
  assign busy         = (r_state != IDLE);

endmodule

// File: tb/tb_aes_ctr.sv
// Bench for aes_ctr: stub core with NIST F.5.1 keystream table,
// counter/keystream model, per-cycle compare process, directed tests.
module tb_aes_ctr;

  localparam int LAT = 6;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic [127:0] ctr_iv = '0;
  logic         ctr_load = 1'b0;
  logic [127:0] s_data = '0;
  logic         s_data_valid = 1'b0;
  logic         s_data_ready;
  logic [127:0] m_data;
  logic         m_data_valid;
  logic         m_data_ready = 1'b1;
  logic [127:0] aes_block;
  logic         aes_valid;
  logic         aes_ready;
  logic [127:0] aes_keystream;
  logic         busy;
  logic         ctr_wrap;

  always #5 clk = ~clk;

  aes_ctr #(.CTR_WIDTH(32)) dut (
    .clk(clk), .rst_n(rst_n),
    .ctr_iv(ctr_iv), .ctr_load(ctr_load),
    .s_data(s_data), .s_data_valid(s_data_valid),
    .s_data_ready(s_data_ready),
    .m_data(m_data), .m_data_valid(m_data_valid),
    .m_data_ready(m_data_ready),
    .aes_block(aes_block), .aes_valid(aes_valid),
    .aes_ready(aes_ready), .aes_keystream(aes_keystream),
    .busy(busy), .ctr_wrap(ctr_wrap)
  );

  int errors = 0;
  int checks = 0;

  // Keystream of the fixed-key core: NIST blocks, else a stand-in mix.
  function automatic logic [127:0] ks(input logic [127:0] b);
    case (b)
      128'hf0f1f2f3f4f5f6f7f8f9fafbfcfdfeff:
        return 128'hec8cdf7398607cb0f2d21675ea9ea1e4;
      128'hf0f1f2f3f4f5f6f7f8f9fafbfcfdff00:
        return 128'h362b7c3c6773516318a077d7fc5073ae;
      default:
        return {b[63:0], b[127:64]} ^ {16{8'h5a}};
    endcase
  endfunction

  function automatic logic [127:0] inc(input logic [127:0] c);
    logic [31:0] lo;
    lo = c[31:0] + 32'd1;
    return {c[127:32], lo};
  endfunction

  task automatic check(input string nm, input logic [127:0] act,
                       input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic timeout(input string nm);
    checks++;
    errors++;
    $display("FAIL %s: timed out", nm);
  endtask

  // Stub core: not reset by rst_n, it is external to the DUT.
  logic         core_rdy = 1'b1;
  logic [127:0] core_out = '0;
  logic [127:0] core_blk = '0;
  int           core_cnt = 0;
  int           ignored = 0;
  int           deaf_target = 0;

  assign aes_ready     = core_rdy;
  assign aes_keystream = core_out;

  always @(posedge clk) begin
    if (core_rdy) begin
      if (aes_valid) begin
        if (ignored < deaf_target) ignored <= ignored + 1;
        else begin
          core_blk <= aes_block;
          core_rdy <= 1'b0;
          core_cnt <= LAT;
        end
      end
    end else if (core_cnt > 1) begin
      core_cnt <= core_cnt - 1;
    end else begin
      core_rdy <= 1'b1;
      core_out <= ks(core_blk);
    end
  end

  // Model state
  logic [127:0] m_ctr = '0;
  logic [127:0] cur_blk = '0;
  logic [127:0] exp_q[$];
  logic [127:0] last_blk = '0;
  int           n_issue = 0;
  int           n_out = 0;
  logic         pv = 1'b0, pr = 1'b0;
  logic [127:0] pd = '0;

  always @(negedge clk) begin
    if (rst_n) begin
      if (aes_valid) begin
        n_issue++;
        last_blk = aes_block;
        check("aes_block", aes_block, cur_blk);
      end
      if (pv && !pr) begin
        check("hold_valid", {127'd0, m_data_valid}, 128'd1);
        check("hold_data", m_data, pd);
      end
      if (m_data_valid && m_data_ready) begin
        n_out++;
        if (exp_q.size() == 0) timeout("unexpected_output");
        else check("m_data", m_data, exp_q.pop_front());
      end
    end
    pv = m_data_valid;
    pr = m_data_ready;
    pd = m_data;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic load(input logic [127:0] iv);
    ctr_iv = iv;
    ctr_load = 1'b1;
    tick();
    ctr_load = 1'b0;
    m_ctr = iv;
  endtask

  task automatic push(input logic [127:0] d);
    bit ok;
    exp_q.push_back(d ^ ks(m_ctr));
    cur_blk = m_ctr;
    m_ctr = inc(m_ctr);
    s_data = d;
    s_data_valid = 1'b1;
    ok = 0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (s_data_ready) begin
        ok = 1;
        break;
      end
    end
    if (!ok) timeout("push");
    tick();
    s_data_valid = 1'b0;
  endtask

  task automatic wait_out(output logic [127:0] got);
    bit ok;
    ok = 0;
    got = '0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (m_data_valid && m_data_ready) begin
        got = m_data;
        ok = 1;
        break;
      end
    end
    if (!ok) timeout("wait_out");
    tick();
  endtask

  task automatic wait_valid();
    bit ok;
    ok = 0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (m_data_valid) begin
        ok = 1;
        break;
      end
    end
    if (!ok) timeout("wait_valid");
  endtask

  task automatic check_reset_outs(input string tag);
    check({tag, "_m_data"}, m_data, '0);
    check({tag, "_m_valid"}, {127'd0, m_data_valid}, '0);
    check({tag, "_s_ready"}, {127'd0, s_data_ready}, '0);
    check({tag, "_aes_block"}, aes_block, '0);
    check({tag, "_aes_valid"}, {127'd0, aes_valid}, '0);
    check({tag, "_busy"}, {127'd0, busy}, '0);
    check({tag, "_wrap"}, {127'd0, ctr_wrap}, '0);
  endtask

  localparam logic [127:0] IV  = 128'hf0f1f2f3f4f5f6f7f8f9fafbfcfdfeff;
  localparam logic [127:0] P1  = 128'h6bc1bee22e409f96e93d7e117393172a;
  localparam logic [127:0] P2  = 128'hae2d8a571e03ac9c9eb76fac45af8e51;
  localparam logic [127:0] C1  = 128'h874d6191b620e3261bef6864990db6ce;
  localparam logic [127:0] C2  = 128'h9806f66b7970fdff8617187bb9fffdff;
  localparam logic [127:0] IV2 = 128'h11111111222222223333333344444444;
  localparam logic [127:0] IVW = 128'h0123456789abcdef01234567ffffffff;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    logic [127:0] got;
    int n0, o0, cnt;
    bit ok;

    repeat (3) tick();
    @(negedge clk);
    check_reset_outs("rst");
    tick();
    rst_n = 1'b1;
    tick();

    // NIST F.5.1 encipher
    load(IV);
    push(P1);
    wait_out(got);
    check("nist_c1", got, C1);
    push(P2);
    wait_out(got);
    check("nist_c2", got, C2);
    check("nist_blk2", last_blk, 128'hf0f1f2f3f4f5f6f7f8f9fafbfcfdff00);

    // Decipher
    load(IV);
    push(C1);
    wait_out(got);
    check("decipher", got, P1);

    // Backpressure for 10 cycles
    load(IV2);
    m_data_ready = 1'b0;
    push(128'hdeadbeef);
    wait_valid();
    n0 = n_issue;
    o0 = n_out;
    cnt = 0;
    repeat (10) begin
      @(negedge clk);
      if (!busy) cnt++;
    end
    check("bp_busy_drop", cnt, 0);
    check("bp_no_issue", n_issue, n0);
    tick();
    m_data_ready = 1'b1;
    wait_out(got);
    @(negedge clk);
    check("bp_one_hs", n_out, o0 + 1);
    check("bp_valid_low", {127'd0, m_data_valid}, '0);
    check("bp_idle", {127'd0, busy}, '0);
    tick();

    // ctr_load during OUT is ignored
    m_data_ready = 1'b0;
    push(128'h0f0e0d0c);
    wait_valid();
    tick();
    ctr_iv = 128'h99;
    ctr_load = 1'b1;
    tick();
    ctr_load = 1'b0;
    m_data_ready = 1'b1;
    wait_out(got);
    push(128'h5555);
    wait_out(got);
    check("load_in_out", last_blk, IV2 + 128'd2);

    // Core misses the first request: exactly one re-pulse
    deaf_target = ignored + 1;
    n0 = n_issue;
    push(128'h1234);
    wait_out(got);
    check("repulse", n_issue - n0, 2);

    // Counter wrap
    load(IVW);
    push(128'h77);
    wait_out(got);
    check("wrap_blk", last_blk, IVW);
    @(negedge clk);
`ifdef AES_CTR_WRAP_ERR_EN
    check("wrap_flag", {127'd0, ctr_wrap}, 128'd1);
    tick();
    s_data = 128'h88;
    s_data_valid = 1'b1;
    cnt = 0;
    repeat (10) begin
      @(negedge clk);
      if (s_data_ready || busy) cnt++;
    end
    check("wrap_refuse", cnt, 0);
    tick();
    s_data_valid = 1'b0;
    load(IV2);
    @(negedge clk);
    check("wrap_clear", {127'd0, ctr_wrap}, '0);
    tick();
    push(128'h88);
    wait_out(got);
    check("wrap_after", last_blk, IV2);
`else
    check("wrap_flag", {127'd0, ctr_wrap}, '0);
    tick();
    push(128'h88);
    wait_out(got);
    check("wrap_next", last_blk, 128'h0123456789abcdef0123456700000000);
`endif

    // Reset during WAIT_DONE
    load(IV2);
    cur_blk = m_ctr;
    exp_q.push_back('0);
    s_data = 128'habc;
    s_data_valid = 1'b1;
    ok = 0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (s_data_ready) s_data_valid = 1'b0;
      if (!aes_ready) begin
        ok = 1;
        break;
      end
    end
    if (!ok) timeout("core_busy");
    s_data_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    check("pre_rst_busy", {127'd0, busy}, 128'd1);
    @(posedge clk);
    #1;
    rst_n = 1'b0;
    exp_q.delete();
    m_ctr = '0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(negedge clk);
    check_reset_outs("midrst");
    cnt = 0;
    repeat (12) begin
      @(negedge clk);
      if (m_data_valid) cnt++;
    end
    check("stale_dropped", cnt, 0);
    check("core_done", {127'd0, aes_ready}, 128'd1);
    tick();
    push(128'h0);
    wait_out(got);
    check("post_rst_blk", last_blk, '0);
    check("post_rst_data", got, {16{8'h5a}});

    repeat (3) tick();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
